// File: rtl/ser_frame_arb_if.sv
// Bundle of the requester and serializer signals around ser_frame_arb.
// The arbiter connects through the slave modport, the surrounding
// environment (requesters plus serializer) through the master modport.
interface ser_frame_arb_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid_i;
  logic [24*N_REQ-1:0] req_data_i;
  logic [N_REQ-1:0]    req_ready_o;
  logic                ser_start_o;
  logic [23:0]         ser_data_o;
  logic [1:0]          ser_cnt_pkt_i;
  logic                frame_done_o;
  logic [ID_W-1:0]     done_id_o;
  logic                busy_o;
  logic                timeout_o;

  modport master (
    output req_valid_i,
    output req_data_i,
    output ser_cnt_pkt_i,
    input  req_ready_o,
    input  ser_start_o,
    input  ser_data_o,
    input  frame_done_o,
    input  done_id_o,
    input  busy_o,
    input  timeout_o
  );

  modport slave (
    input  req_valid_i,
    input  req_data_i,
    input  ser_cnt_pkt_i,
    output req_ready_o,
    output ser_start_o,
    output ser_data_o,
    output frame_done_o,
    output done_id_o,
    output busy_o,
    output timeout_o
  );
endinterface

// File: rtl/ser_frame_arb.sv
// Round-robin arbiter sharing one 24-bit frame serializer among N_REQ
// requesters. The winning payload is latched and held for the whole frame
// (comma + 3 bytes); completion is seen when the serializer packet counter
// wraps from 3 back to 0, after which a done pulse reports the requester ID.
// Optional build macro SER_FRAME_ARB_TIMEOUT_EN adds a per-frame watchdog
// of TIMEOUT_CYC clocks and a sticky timeout flag.
module ser_frame_arb #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic           clk_i,
  input logic           rst_ni,
  ser_frame_arb_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);
  localparam logic [ID_W:0]   N_EXT   = (ID_W+1)'(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cur_id;
  logic [ID_W-1:0]  done_id_q;
  logic [23:0]      ser_data_q;
  logic             ser_start_q;
  logic             frame_done_q;
  logic [1:0]       cnt_prev;

  logic             grant_any;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W:0]    scan_sum;
  logic [ID_W-1:0]  scan_id;
  logic [23:0]      grant_data;
  logic [N_REQ-1:0] grant_oh;
  logic             frame_end;
  logic [ID_W-1:0]  next_rr;

`ifdef SER_FRAME_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout_q;
`endif

  // Round-robin search: scanning offsets from the top down lets the
  // smallest offset from rr_ptr win without an early exit.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_sum  = '0;
    scan_id   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (scan_sum >= N_EXT) begin
        scan_sum = scan_sum - N_EXT;
      end
      scan_id = scan_sum[ID_W-1:0];
      if (bus.req_valid_i[scan_id]) begin
        grant_any = 1'b1;
        grant_id  = scan_id;
      end
    end
  end

  // Payload mux and one-hot ready; ready only exists while idle and out of reset.
  always_comb begin
    grant_data = '0;
    grant_oh   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_id == ID_W'(k)) begin
        grant_data = bus.req_data_i[24*k +: 24];
        grant_oh[k] = grant_any && (state == ST_IDLE) && rst_ni;
      end
    end
  end

  assign frame_end = (cnt_prev == 2'd3) && (bus.ser_cnt_pkt_i == 2'd0);
  assign next_rr   = (cur_id == LAST_ID) ? '0 : cur_id + ID_W'(1);

  // Arbiter FSM with all outputs registered; reset aborts any frame in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      cur_id       <= '0;
      done_id_q    <= '0;
      ser_data_q   <= '0;
      ser_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_prev     <= 2'd0;
`ifdef SER_FRAME_ARB_TIMEOUT_EN
      tmo_cnt      <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      cnt_prev <= bus.ser_cnt_pkt_i;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            ser_data_q  <= grant_data;
            cur_id      <= grant_id;
            ser_start_q <= 1'b1;
            state       <= ST_START;
`ifdef SER_FRAME_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end
        ST_START: begin
          ser_start_q <= 1'b0;
          state       <= ST_BUSY;
        end
        ST_BUSY: begin
          if (frame_end) begin
            frame_done_q <= 1'b1;
            done_id_q    <= cur_id;
            state        <= ST_DONE;
          end
`ifdef SER_FRAME_ARB_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
              frame_done_q <= 1'b1;
              done_id_q    <= cur_id;
              timeout_q    <= 1'b1;
              state        <= ST_DONE;
            end
          end
`endif
        end
        ST_DONE: begin
          frame_done_q <= 1'b0;
          rr_ptr       <= next_rr;
          state        <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o  = grant_oh;
  assign bus.ser_start_o  = ser_start_q;
  assign bus.ser_data_o   = ser_data_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.done_id_o    = done_id_q;
  assign bus.busy_o       = (state != ST_IDLE);
`ifdef SER_FRAME_ARB_TIMEOUT_EN
  assign bus.timeout_o    = timeout_q;
`else
  assign bus.timeout_o    = 1'b0;
`endif
endmodule

// File: tb/tb_ser_frame_arb.sv
// Directed testbench for ser_frame_arb (N_REQ=4, TIMEOUT_CYC=16).
// Drives requesters and plays the serializer packet counter by hand.
module tb_ser_frame_arb;
   localparam int N = 4;

   logic clk_i = 1'b0;
   logic rst_ni;
   int   vectors = 0;
   int   errors  = 0;

   logic [23:0] pay [N] = '{24'hA1B2C3, 24'h1A2B3C, 24'h5E6F70, 24'h3C4D5E};

   ser_frame_arb_if #(.N_REQ(N)) bus();

   ser_frame_arb #(.N_REQ(N), .TIMEOUT_CYC(16)) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus)
   );

   // Free-running 10 ns clock
   always #5 clk_i = ~clk_i;

   // Safety net so the run can never hang
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic [N-1:0] valid);
      bus.req_valid_i = valid;
      #1;
   endtask

   task automatic setData(input int id, input logic [23:0] d);
      bus.req_data_i[24*id +: 24] = d;
   endtask

   task automatic doReset();
      rst_ni = 1'b0;
      bus.req_valid_i   = '0;
      bus.ser_cnt_pkt_i = 2'd0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      #1;
   endtask

   // One full frame: accept, start pulse, counter 1,2,3,0, done pulse, idle.
   task automatic runFrame(input int exp_id, input logic [23:0] exp_data,
                           input logic [23:0] busy_data, input string tag);
      #1;
      checkOutput({tag, "/ready"}, 32'(bus.req_ready_o), 32'(1 << exp_id));
      checkOutput({tag, "/idle_busy"}, 32'(bus.busy_o), 32'd0);
      tick();
      checkOutput({tag, "/start"}, 32'(bus.ser_start_o), 32'd1);
      checkOutput({tag, "/data"}, 32'(bus.ser_data_o), 32'(exp_data));
      checkOutput({tag, "/ready_start"}, 32'(bus.req_ready_o), 32'd0);
      tick();
      checkOutput({tag, "/start_off"}, 32'(bus.ser_start_o), 32'd0);
      setData(exp_id, busy_data);
      for (int v = 1; v <= 3; v++) begin
         bus.ser_cnt_pkt_i = 2'(v);
         tick();
         checkOutput({tag, "/no_done"}, 32'(bus.frame_done_o), 32'd0);
         checkOutput({tag, "/hold"}, 32'(bus.ser_data_o), 32'(exp_data));
         checkOutput({tag, "/ready_busy"}, 32'(bus.req_ready_o), 32'd0);
      end
      bus.ser_cnt_pkt_i = 2'd0;
      tick();
      checkOutput({tag, "/done"}, 32'(bus.frame_done_o), 32'd1);
      checkOutput({tag, "/done_id"}, 32'(bus.done_id_o), 32'(exp_id));
      checkOutput({tag, "/done_busy"}, 32'(bus.busy_o), 32'd1);
      tick();
      checkOutput({tag, "/done_off"}, 32'(bus.frame_done_o), 32'd0);
      checkOutput({tag, "/busy_off"}, 32'(bus.busy_o), 32'd0);
   endtask

   int exp_pair [4] = '{1, 3, 1, 3};
   int exp_all  [5] = '{0, 1, 2, 3, 0};
   int done_at;
   logic seen_done;

   initial begin
      bus.req_data_i = '0;
      for (int k = 0; k < N; k++) setData(k, pay[k]);
      doReset();

      // Reset state
      rst_ni = 1'b0;
      #1;
      checkOutput("rst/ready", 32'(bus.req_ready_o), 32'd0);
      checkOutput("rst/start", 32'(bus.ser_start_o), 32'd0);
      checkOutput("rst/data", 32'(bus.ser_data_o), 32'd0);
      checkOutput("rst/done", 32'(bus.frame_done_o), 32'd0);
      checkOutput("rst/done_id", 32'(bus.done_id_o), 32'd0);
      checkOutput("rst/busy", 32'(bus.busy_o), 32'd0);
      checkOutput("rst/timeout", 32'(bus.timeout_o), 32'd0);
      doReset();

      // Single requester
      applyStimulus(4'b0001);
      runFrame(0, 24'hA1B2C3, 24'hA1B2C3, "single");
      applyStimulus(4'b0000);
      checkOutput("single/data_held", 32'(bus.ser_data_o), 32'hA1B2C3);

      // Two simultaneous requesters alternate
      doReset();
      applyStimulus(4'b1010);
      for (int f = 0; f < 4; f++) runFrame(exp_pair[f], pay[exp_pair[f]], pay[exp_pair[f]], "pair");

      // All four requesting: strict rotation
      applyStimulus(4'b1111);
      for (int f = 0; f < 5; f++) runFrame(exp_all[f], pay[exp_all[f]], pay[exp_all[f]], "all");
      applyStimulus(4'b0000);

      // Payload change during the frame must not reach ser_data_o
      applyStimulus(4'b0100);
      runFrame(2, 24'h5E6F70, 24'h123456, "stable");
      applyStimulus(4'b0000);

      // Reset in the middle of a frame with counter at 2
      setData(3, 24'h5A5A5A);
      applyStimulus(4'b1000);
      checkOutput("mid/ready", 32'(bus.req_ready_o), 32'b1000);
      tick();
      checkOutput("mid/start", 32'(bus.ser_start_o), 32'd1);
      tick();
      bus.ser_cnt_pkt_i = 2'd1;
      tick();
      bus.ser_cnt_pkt_i = 2'd2;
      tick();
      #3;
      rst_ni = 1'b0;
      applyStimulus(4'b1111);
      checkOutput("mid/ready_rst", 32'(bus.req_ready_o), 32'd0);
      checkOutput("mid/data_rst", 32'(bus.ser_data_o), 32'd0);
      checkOutput("mid/busy_rst", 32'(bus.busy_o), 32'd0);
      checkOutput("mid/done_rst", 32'(bus.frame_done_o), 32'd0);
      checkOutput("mid/start_rst", 32'(bus.ser_start_o), 32'd0);
      bus.ser_cnt_pkt_i = 2'd3;
      tick();
      bus.ser_cnt_pkt_i = 2'd0;
      tick();
      checkOutput("mid/no_done", 32'(bus.frame_done_o), 32'd0);
      rst_ni = 1'b1;
      #1;
      checkOutput("mid/restart", 32'(bus.req_ready_o), 32'b0001);
      runFrame(0, pay[0], pay[0], "mid");

      // Serializer stalls with its counter at 1
      applyStimulus(4'b0010);
      checkOutput("stall/ready", 32'(bus.req_ready_o), 32'b0010);
      tick();
      applyStimulus(4'b0000);
      tick();
      bus.ser_cnt_pkt_i = 2'd1;
      seen_done = 1'b0;
      done_at   = 0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (!seen_done && bus.frame_done_o) begin
            seen_done = 1'b1;
            done_at   = n;
            checkOutput("stall/done_id", 32'(bus.done_id_o), 32'd1);
         end
      end
`ifdef SER_FRAME_ARB_TIMEOUT_EN
      checkOutput("stall/done_seen", 32'(seen_done), 32'd1);
      checkOutput("stall/done_at", 32'(done_at), 32'd16);
      checkOutput("stall/timeout_sticky", 32'(bus.timeout_o), 32'd1);
      checkOutput("stall/busy", 32'(bus.busy_o), 32'd0);
`else
      checkOutput("stall/done_seen", 32'(seen_done), 32'd0);
      checkOutput("stall/busy", 32'(bus.busy_o), 32'd1);
      checkOutput("stall/timeout", 32'(bus.timeout_o), 32'd0);
`endif
      doReset();
      checkOutput("stall/busy_rst", 32'(bus.busy_o), 32'd0);
      checkOutput("stall/timeout_rst", 32'(bus.timeout_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
